// File: rtl/fractured_lane_accumulator.sv
// Per-lane burst accumulator for the 38-bit fractured result, with a valid/ready result hold.
// Optional clamp-on-overflow build: define FRAC_ACC_SAT_EN (default build wraps modulo 2^ACC_W).

module fla_lane_add #(
  parameter int LANE_W = 19,
  parameter int ACC_W  = 24
) (
  input  logic [ACC_W-1:0]  base_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);
`ifdef FRAC_ACC_SAT_EN
  logic [ACC_W:0] full;
  assign full  = {1'b0, base_i} + (ACC_W+1)'(lane_i);
  assign ovf_o = full[ACC_W];
  // Once clamped, later beats overflow again and keep the lane pinned at max
  assign sum_o = full[ACC_W] ? '1 : full[ACC_W-1:0];
`else
  assign sum_o = base_i + ACC_W'(lane_i);
  assign ovf_o = 1'b0;
`endif
endmodule

module fractured_lane_accumulator #(
  parameter int LANE_W = 19,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*LANE_W-1:0] z_in,
  input  logic [LEN_W-1:0]    acc_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    acc_hi,
  output logic [ACC_W-1:0]    acc_lo,
  output logic                sat_hi,
  output logic                sat_lo,
  output logic                busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [1:0][ACC_W-1:0]  acc_q, acc_d, sum;
  logic [1:0]             sat_q, sat_d, ovf;
  logic [LEN_W-1:0]       count_q, count_d, len_q, len_d, cnt_inc, eff_len;
  logic                   accept;

  // Lane 0 = lo, lane 1 = hi; a fresh burst adds onto zero so lanes start zero-extended
  for (genvar l = 0; l < 2; l++) begin : g_lane
    fla_lane_add #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_add (
      .base_i (state_q == S_IDLE ? '0 : acc_q[l]),
      .lane_i (z_in[l*LANE_W +: LANE_W]),
      .sum_o  (sum[l]),
      .ovf_o  (ovf[l])
    );
  end

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = count_q + 1'b1;
  assign eff_len   = (acc_len == '0) ? LEN_W'(1) : acc_len;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: if (accept) begin
        acc_d   = sum;
        sat_d   = ovf;
        count_d = LEN_W'(1);
        len_d   = eff_len;
        state_d = (eff_len == LEN_W'(1)) ? S_HOLD : S_ACCUM;
      end
      S_ACCUM: if (accept) begin
        acc_d   = sum;
        sat_d   = sat_q | ovf;
        count_d = cnt_inc;
        if (cnt_inc == len_q) state_d = S_HOLD;
      end
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sat_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  assign acc_lo = acc_q[0];
  assign acc_hi = acc_q[1];
  assign sat_lo = sat_q[0];
  assign sat_hi = sat_q[1];
endmodule

// File: tb/tb_fractured_lane_accumulator.sv
// Directed bench: expected burst results are queued at issue time and checked by a monitor on transfer.
module tb_fractured_lane_accumulator;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [37:0] z_in;
  logic [7:0]  acc_len;
  logic [23:0] acc_hi, acc_lo;
  logic        sat_hi, sat_lo, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] hi;
    logic [23:0] lo;
    logic        sh;
    logic        sl;
  } exp_t;
  exp_t sb[$];

  fractured_lane_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .z_in(z_in), .acc_len(acc_len), .out_valid(out_valid), .out_ready(out_ready),
    .acc_hi(acc_hi), .acc_lo(acc_lo), .sat_hi(sat_hi), .sat_lo(sat_lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] hi, input logic [23:0] lo, input logic s);
    exp_t e;
    e.hi = hi; e.lo = lo; e.sh = s; e.sl = s;
    sb.push_back(e);
  endtask

  // Present one beat and hold it until the edge that accepts it
  task automatic send(input logic [37:0] z, input logic [7:0] len);
    int n = 0;
    in_valid = 1'b1; z_in = z; acc_len = len;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("send_timeout_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("acc_hi", 32'(acc_hi), 32'(e.hi));
        chk("acc_lo", 32'(acc_lo), 32'(e.lo));
        chk("sat_hi", 32'(sat_hi), 32'(e.sh));
        chk("sat_lo", 32'(sat_lo), 32'(e.sl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [23:0] hold_hi, hold_lo;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; z_in = '0; acc_len = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_acc_hi", 32'(acc_hi), 0);
    chk("rst_acc_lo", 32'(acc_lo), 0);
    chk("rst_sat", 32'({sat_hi, sat_lo}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // 1: single beat, latency of one cycle
    push(24'd0, 24'd510, 1'b0);
    send(38'd510, 8'd1);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_in_ready_hold", 32'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t1_back_idle", 32'(out_valid), 0);

    // 2: three-beat burst, result shown for one cycle only
    push(24'd0, 24'd1530, 1'b0);
    for (int i = 0; i < 3; i++) send(38'd510, 8'd3);
    chk("t2_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    chk("t2_out_valid_drop", 32'(out_valid), 0);
    chk("t2_busy_idle", 32'(busy), 0);

    // 3: both lanes, gaps between beats
    push(24'd40, 24'd12, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send({19'd10, 19'd3}, 8'd4);
      if (i < 3) begin
        repeat (2) begin
          @(negedge clk);
          chk("t3_gap_busy", 32'(busy), 1);
          chk("t3_gap_in_ready", 32'(in_ready), 1);
          @(posedge clk); #1;
        end
      end
    end
    chk("t3_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;

    // 4: overflow behaviour over 40 max-valued beats
`ifdef FRAC_ACC_SAT_EN
    push(24'd16777215, 24'd16777215, 1'b1);
`else
    push(24'd4194264, 24'd4194264, 1'b0);
`endif
    for (int i = 0; i < 40; i++) send(38'h3F_FFFF_FFFF, 8'd40);
    chk("t4_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;

    // 5: backpressure with a beat waiting upstream
    out_ready = 1'b0;
    push(24'd200, 24'd10, 1'b0);
    send({19'd100, 19'd5}, 8'd2);
    send({19'd100, 19'd5}, 8'd2);
    chk("t5_out_valid", 32'(out_valid), 1);
    hold_hi = acc_hi; hold_lo = acc_lo;
    in_valid = 1'b1; z_in = {19'd77, 19'd99}; acc_len = 8'd1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_stable_hi", 32'(acc_hi), 32'(hold_hi));
      chk("t5_stable_lo", 32'(acc_lo), 32'(hold_lo));
      chk("t5_in_ready", 32'(in_ready), 0);
      chk("t5_out_valid_held", 32'(out_valid), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("t5_nothing_consumed", 32'(busy), 0);

    // 6: reset mid-burst, then zero length treated as one
    send({19'd1, 19'd2}, 8'd5);
    send({19'd1, 19'd2}, 8'd5);
    chk("t6_busy_mid", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_acc_hi", 32'(acc_hi), 0);
    chk("t6_rst_acc_lo", 32'(acc_lo), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    push(24'd0, 24'd7, 1'b0);
    send(38'd7, 8'd0);
    chk("t6_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    chk("t6_idle", 32'(busy), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
